// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/stall controls and the F/D register outputs.
// The master modport is the fetch unit; the slave modport is its environment (memory, PC-update, decode).
interface fetch_unit_if;
  // stall=1 holds the F/D register for that edge (pc_load is still honoured);
  // f_valid=1 means the F/D register carries a real AOK/HLT instruction, 0 is a bubble.
  logic        stall;
  logic        pc_load;
  logic [63:0] new_pc;
  logic [63:0] pc;
  logic [7:0]  Byte0;
  logic [71:0] Byte19;
  logic        imem_error;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        f_valid;
  logic [1:0]  stat;
  logic [1:0]  state_dbg;  // RUN=0, HALTED=1, FAULT=2

  modport master (
    input  stall, pc_load, new_pc, Byte0, Byte19, imem_error,
    output pc, icode, ifun, rA, rB, valC, valP, f_valid, stat, state_dbg
  );

  modport slave (
    output stall, pc_load, new_pc, Byte0, Byte19, imem_error,
    input  pc, icode, ifun, rA, rB, valC, valP, f_valid, stat, state_dbg
  );
endinterface

// File: rtl/fetch_unit.sv
// Y86-64 style fetch stage: combinational decode of the current PC, registered F/D outputs, RUN/HALTED/FAULT FSM.
// Optional FETCH_PC_BOUND_CHECK_EN also raises ADR for instructions straddling the end of a 2 KiB memory.
module fetch_unit (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  state_t      state, state_nx;
  logic [63:0] pc_q, pc_nx;
  logic        latch;

  logic [3:0]  d_icode, d_ifun, d_rA, d_rB, len;
  logic [63:0] d_valC, d_valP;
  logic [1:0]  d_stat;
  logic        need_regs, need_valc, bad_icode, bad_ifun, adr;

  logic [3:0]  icode_q, ifun_q, rA_q, rB_q;
  logic [63:0] valC_q, valP_q;
  logic        f_valid_q;
  logic [1:0]  stat_q;

`ifdef FETCH_PC_BOUND_CHECK_EN
  logic [64:0] last_byte;
`endif

  always_comb begin
    d_icode   = bus.Byte0[7:4];
    d_ifun    = bus.Byte0[3:0];
    len       = 4'd1;
    need_regs = 1'b0;
    need_valc = 1'b0;
    bad_icode = 1'b0;
    case (d_icode)
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  need_regs = 1'b1; end
      4'h7, 4'h8:             begin len = 4'd9;  need_valc = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 4'd10; need_regs = 1'b1; need_valc = 1'b1; end
      default:                bad_icode = 1'b1;
    endcase
    case (d_icode)
      4'h6:       bad_ifun = (d_ifun > 4'd3);
      4'h2, 4'h7: bad_ifun = (d_ifun > 4'd6);
      default:    bad_ifun = (d_ifun != 4'd0);
    endcase
    d_rA   = need_regs ? bus.Byte19[7:4] : 4'hF;
    d_rB   = need_regs ? bus.Byte19[3:0] : 4'hF;
    d_valC = !need_valc ? 64'd0 : (need_regs ? bus.Byte19[71:8] : bus.Byte19[63:0]);
    d_valP = pc_q + {60'd0, len};
    adr    = bus.imem_error;
`ifdef FETCH_PC_BOUND_CHECK_EN
    // Address of the instruction's last byte, kept 65 bits wide so it cannot wrap.
    last_byte = {1'b0, pc_q} + {61'd0, len} - 65'd1;
    if (last_byte > 65'd2047) adr = 1'b1;
`endif
    if (adr)                        d_stat = ADR;
    else if (bad_icode || bad_ifun) d_stat = INS;
    else if (d_icode == 4'h0)       d_stat = HLT;
    else                            d_stat = AOK;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    latch    = 1'b0;
    if (state == RUN) begin
      latch = !bus.stall;
      // Redirect wins over stall; otherwise calls and jumps are predicted taken.
      if (bus.pc_load)
        pc_nx = bus.new_pc;
      else if (!bus.stall)
        pc_nx = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valC : d_valP;
      if (latch) begin
        case (d_stat)
          HLT:      state_nx = HALTED;
          ADR, INS: state_nx = FAULT;
          default:  state_nx = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc_q      <= 64'd0;
      icode_q   <= 4'h1;
      ifun_q    <= 4'h0;
      rA_q      <= 4'hF;
      rB_q      <= 4'hF;
      valC_q    <= 64'd0;
      valP_q    <= 64'd0;
      f_valid_q <= 1'b0;
      stat_q    <= AOK;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (latch) begin
        icode_q   <= d_icode;
        ifun_q    <= d_ifun;
        rA_q      <= d_rA;
        rB_q      <= d_rB;
        valC_q    <= d_valC;
        valP_q    <= d_valP;
        f_valid_q <= (d_stat == AOK) || (d_stat == HLT);
        stat_q    <= d_stat;
      end else if (state != RUN) begin
        icode_q   <= 4'h1;
        f_valid_q <= 1'b0;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.rA        = rA_q;
  assign bus.rB        = rB_q;
  assign bus.valC      = valC_q;
  assign bus.valP      = valP_q;
  assign bus.f_valid   = f_valid_q;
  assign bus.stat      = stat_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction streams against a table-driven model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [1:0]  stat;
  } dec_t;

  logic [63:0] m_pc;
  int          m_st;   // 0 running, 1 halted, 2 faulted
  dec_t        m_out;
  logic        m_fv;

  function automatic dec_t ref_decode(logic [63:0] pc, logic [7:0] b0, logic [71:0] b19, logic ierr);
    dec_t d;
    int   len;
    bit   regs, cst, ok_icode, ok_ifun, adr;
    d.icode  = b0[7:4];
    d.ifun   = b0[3:0];
    ok_icode = 1;
    case (d.icode)
      0, 1, 9:        len = 1;
      2, 6, 10, 11:   len = 2;
      7, 8:           len = 9;
      3, 4, 5:        len = 10;
      default: begin len = 1; ok_icode = 0; end
    endcase
    regs   = (len == 2) || (len == 10);
    cst    = (len >= 9);
    d.rA   = regs ? b19[7:4] : 4'hF;
    d.rB   = regs ? b19[3:0] : 4'hF;
    d.valC = !cst ? 64'd0 : (regs ? b19[71:8] : b19[63:0]);
    d.valP = pc + 64'(len);
    if (d.icode == 6) ok_ifun = (d.ifun <= 3);
    else if (d.icode == 2 || d.icode == 7) ok_ifun = (d.ifun <= 6);
    else ok_ifun = (d.ifun == 0);
    adr = ierr;
`ifdef FETCH_PC_BOUND_CHECK_EN
    if ({1'b0, pc} + 65'(len) - 65'd1 > 65'd2047) adr = 1;
`endif
    if (adr) d.stat = 2'd2;
    else if (!ok_icode || !ok_ifun) d.stat = 2'd3;
    else if (d.icode == 0) d.stat = 2'd1;
    else d.stat = 2'd0;
    return d;
  endfunction

  task automatic drive(input logic s, input logic pl, input logic [63:0] np,
                       input logic [7:0] b0, input logic [71:0] b19, input logic e);
    bus.stall      = s;
    bus.pc_load    = pl;
    bus.new_pc     = np;
    bus.Byte0      = b0;
    bus.Byte19     = b19;
    bus.imem_error = e;
  endtask

  // Advance the model by one edge from the currently driven inputs, then let the DUT take the edge.
  task automatic tick();
    dec_t d;
    if (rst) begin
      m_pc = 64'd0; m_st = 0; m_fv = 1'b0;
      m_out.icode = 4'h1; m_out.ifun = 4'h0; m_out.rA = 4'hF; m_out.rB = 4'hF;
      m_out.valC = 64'd0; m_out.valP = 64'd0; m_out.stat = 2'd0;
    end else if (m_st == 0) begin
      d = ref_decode(m_pc, bus.Byte0, bus.Byte19, bus.imem_error);
      if (!bus.stall) begin
        m_out = d;
        m_fv  = (d.stat <= 2'd1);
        m_st  = (d.stat == 2'd1) ? 1 : (d.stat >= 2'd2) ? 2 : 0;
      end
      if (bus.pc_load) m_pc = bus.new_pc;
      else if (!bus.stall) m_pc = (d.icode == 7 || d.icode == 8) ? d.valC : d.valP;
    end else begin
      m_out.icode = 4'h1;
      m_fv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 64'h55, 8'h30, 72'h0, 1'b0);
    tick();
    n_total++; if (bus.pc !== 64'd0) $display("FAIL reset_pc: got %0d want 0", bus.pc); else n_pass++;
    n_total++; if ({bus.icode, bus.ifun, bus.rA, bus.rB} !== 16'h10FF)
      $display("FAIL reset_fields: got %h want 10ff", {bus.icode, bus.ifun, bus.rA, bus.rB}); else n_pass++;
    n_total++; if ({bus.valC, bus.valP} !== 128'd0)
      $display("FAIL reset_vals: got %h want 0", {bus.valC, bus.valP}); else n_pass++;
    n_total++; if ({bus.f_valid, bus.stat} !== 3'b000)
      $display("FAIL reset_fv_stat: got %b want 000", {bus.f_valid, bus.stat}); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus.pc !== 64'd0) $display("FAIL release_pc: got %0d want 0", bus.pc); else n_pass++;
  endtask

  task automatic test_irmovq();
    drive(1'b0, 1'b0, 64'd0, 8'h30, 72'h00_0000_0000_0000_0AF8, 1'b0);
    tick();
    n_total++; if ({bus.icode, bus.rA, bus.rB} !== 12'h3F8)
      $display("FAIL irmov_regs: got %h want 3f8", {bus.icode, bus.rA, bus.rB}); else n_pass++;
    n_total++; if (bus.valC !== 64'd10) $display("FAIL irmov_valC: got %0d want 10", bus.valC); else n_pass++;
    n_total++; if (bus.valP !== 64'd10) $display("FAIL irmov_valP: got %0d want 10", bus.valP); else n_pass++;
    n_total++; if (bus.pc !== 64'd10) $display("FAIL irmov_pc: got %0d want 10", bus.pc); else n_pass++;
    n_total++; if ({bus.f_valid, bus.stat} !== 3'b100)
      $display("FAIL irmov_fv_stat: got %b want 100", {bus.f_valid, bus.stat}); else n_pass++;
  endtask

  task automatic test_call();
    drive(1'b1, 1'b1, 64'd31, 8'h10, 72'h0, 1'b0);
    tick();
    n_total++; if (bus.pc !== 64'd31) $display("FAIL call_setup_pc: got %0d want 31", bus.pc); else n_pass++;
    drive(1'b0, 1'b0, 64'd0, 8'h80, {8'h00, 64'd112}, 1'b0);
    tick();
    n_total++; if (bus.valP !== 64'd40) $display("FAIL call_valP: got %0d want 40", bus.valP); else n_pass++;
    n_total++; if (bus.pc !== 64'd112) $display("FAIL call_pc: got %0d want 112", bus.pc); else n_pass++;
    n_total++; if ({bus.icode, bus.rA, bus.rB, bus.valC} !== {12'h8FF, 64'd112})
      $display("FAIL call_fields: got %h want 8ff_%h", {bus.icode, bus.rA, bus.rB, bus.valC}, 64'd112); else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 64'd145, 8'h30, {8'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
      tick();
      n_total++; if (bus.pc !== 64'd145) $display("FAIL stall_pc%0d: got %0d want 145", i, bus.pc); else n_pass++;
      n_total++; if ({bus.icode, bus.rA, bus.rB, bus.valC, bus.valP, bus.f_valid} !== {12'h8FF, 64'd112, 64'd40, 1'b1})
        $display("FAIL stall_hold%0d: got %h", i, {bus.icode, bus.rA, bus.rB, bus.valC, bus.valP, bus.f_valid}); else n_pass++;
    end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 64'd0, 8'h00, {8'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
    tick();
    n_total++; if ({bus.icode, bus.f_valid, bus.stat} !== {4'h0, 1'b1, 2'd1})
      $display("FAIL halt_latch: got %h want %h", {bus.icode, bus.f_valid, bus.stat}, {4'h0, 1'b1, 2'd1}); else n_pass++;
    n_total++; if (bus.valP !== 64'd146) $display("FAIL halt_valP: got %0d want 146", bus.valP); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 64'd7, 8'h30, 72'h0, 1'b0);
      tick();
      n_total++; if (bus.pc !== 64'd146) $display("FAIL halted_pc%0d: got %0d want 146", i, bus.pc); else n_pass++;
      n_total++; if ({bus.icode, bus.f_valid, bus.stat, bus.state_dbg} !== {4'h1, 1'b0, 2'd1, 2'd1})
        $display("FAIL halted_out%0d: got %h", i, {bus.icode, bus.f_valid, bus.stat, bus.state_dbg}); else n_pass++;
    end
  endtask

  task automatic test_fault();
    rst = 1'b1;
    drive(1'b1, 1'b1, 64'd99, 8'h64, 72'h0, 1'b0);
    tick();
    rst = 1'b0;
    n_total++; if ({bus.pc, bus.stat, bus.state_dbg, bus.icode} !== {64'd0, 2'd0, 2'd0, 4'h1})
      $display("FAIL halted_reset: got %h", {bus.pc, bus.stat, bus.state_dbg, bus.icode}); else n_pass++;
    drive(1'b0, 1'b0, 64'd0, 8'h64, 72'h0, 1'b0);
    tick();
    n_total++; if ({bus.stat, bus.f_valid, bus.state_dbg} !== {2'd3, 1'b0, 2'd2})
      $display("FAIL ins_fault: got %b want 11010", {bus.stat, bus.f_valid, bus.state_dbg}); else n_pass++;
    drive(1'b0, 1'b1, 64'd99, 8'h30, 72'h0, 1'b0);
    tick();
    n_total++; if ({bus.pc, bus.icode, bus.stat} !== {m_pc, 4'h1, 2'd3})
      $display("FAIL fault_frozen: got pc %0d icode %h stat %0d want pc %0d icode 1 stat 3",
               bus.pc, bus.icode, bus.stat, m_pc); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 8'h64, 72'h0, 1'b1);
    tick();
    n_total++; if ({bus.stat, bus.f_valid} !== {2'd2, 1'b0})
      $display("FAIL adr_priority: got %b want 100", {bus.stat, bus.f_valid}); else n_pass++;
  endtask

  task automatic test_bound();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 64'd2040, 8'h10, 72'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 64'd0, 8'h30, {8'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
    tick();
`ifdef FETCH_PC_BOUND_CHECK_EN
    n_total++; if ({bus.stat, bus.f_valid} !== {2'd2, 1'b0})
      $display("FAIL bound_stat: got %b want 100", {bus.stat, bus.f_valid}); else n_pass++;
`else
    n_total++; if ({bus.stat, bus.f_valid} !== {2'd0, 1'b1})
      $display("FAIL bound_stat: got %b want 001", {bus.stat, bus.f_valid}); else n_pass++;
    n_total++; if (bus.valP !== 64'd2050) $display("FAIL bound_valP: got %0d want 2050", bus.valP); else n_pass++;
`endif
    n_total++; if (bus.pc !== 64'd2050) $display("FAIL bound_pc: got %0d want 2050", bus.pc); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  ic, fn;
    logic [71:0] b19;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) ic = 4'h0;
      else if (r < 5) ic = 4'($urandom_range(12, 15));
      else ic = 4'($urandom_range(1, 11));
      case (ic)
        4'h6:       fn = 4'($urandom_range(0, 3));
        4'h2, 4'h7: fn = 4'($urandom_range(0, 6));
        default:    fn = 4'h0;
      endcase
      if ($urandom_range(0, 9) == 0) fn = 4'($urandom_range(0, 15));
      b19 = {8'($urandom), 32'($urandom), 32'($urandom)};
      if (ic == 4'h7 || ic == 4'h8) b19[63:0] = 64'($urandom_range(0, 1500));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 64'($urandom_range(0, 1500)),
            {ic, fn}, b19, $urandom_range(0, 40) == 0);
      rst = (m_st != 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      tick();
      rst = 1'b0;
      n_total++; if (bus.pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, bus.pc, m_pc); else n_pass++;
      n_total++; if ({bus.icode, bus.ifun} !== {m_out.icode, m_out.ifun})
        $display("FAIL rnd_op[%0d]: got %h want %h", i, {bus.icode, bus.ifun}, {m_out.icode, m_out.ifun}); else n_pass++;
      n_total++; if ({bus.stat, bus.f_valid} !== {m_out.stat, m_fv})
        $display("FAIL rnd_stat[%0d]: got %b want %b", i, {bus.stat, bus.f_valid}, {m_out.stat, m_fv}); else n_pass++;
      if (m_fv) begin
        n_total++; if ({bus.rA, bus.rB, bus.valC, bus.valP} !== {m_out.rA, m_out.rB, m_out.valC, m_out.valP})
          $display("FAIL rnd_vals[%0d]: got %h want %h", i, {bus.rA, bus.rB, bus.valC, bus.valP},
                   {m_out.rA, m_out.rB, m_out.valC, m_out.valP}); else n_pass++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 8'h10, 72'h0, 1'b0);
    test_reset();
    test_irmovq();
    test_call();
    test_stall();
    test_halt();
    test_fault();
    test_bound();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
